// File: rtl/mode_speed_selector_pkg.sv
// Shared encodings, debounce FSM states and reset values for the mode/speed selector.
package mode_speed_selector_pkg;

  typedef enum logic [1:0] {
    MODE_NONE  = 2'b00,
    MODE_RULE1 = 2'b01,
    MODE_RULE2 = 2'b10,
    MODE_AUTO  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    SPD_50M = 2'b00,
    SPD_1HZ = 2'b01,
    SPD_2HZ = 2'b10,
    SPD_4HZ = 2'b11
  } spd_t;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_t;

  localparam mode_t     MODE_RST    = MODE_NONE;
  localparam spd_t      SPD_RST     = SPD_1HZ;
  localparam logic      BTN_RST_LVL = 1'b1;
  localparam db_state_t DB_RST      = RELEASED;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_NONE:  return MODE_RULE1;
      MODE_RULE1: return MODE_RULE2;
      MODE_RULE2: return MODE_AUTO;
      default:    return MODE_NONE;
    endcase
  endfunction

  // 50 MHz sits after 4 Hz in the cycle so the slow rates come first after reset.
  function automatic spd_t next_spd(input spd_t s);
    case (s)
      SPD_1HZ: return SPD_2HZ;
      SPD_2HZ: return SPD_4HZ;
      SPD_4HZ: return SPD_50M;
      default: return SPD_1HZ;
    endcase
  endfunction

endpackage

// File: rtl/mode_speed_selector_if.sv
// Button inputs and selector outputs of the mode/speed selector; master is the selector side.
interface mode_speed_selector_if;
  logic       btn_mode_n;
  logic       btn_speed_n;
  logic [1:0] mode;
  logic       clk_sw_1;
  logic       clk_sw_2;
  logic       upd;

  modport master (
    input  btn_mode_n, btn_speed_n,
    output mode, clk_sw_1, clk_sw_2, upd
  );

  modport slave (
    output btn_mode_n, btn_speed_n,
    input  mode, clk_sw_1, clk_sw_2, upd
  );
endinterface

// File: rtl/mode_speed_selector_button_debouncer.sv
// Synchronizes and debounces one active-low button; press_ev is a one-cycle pulse per accepted press.
// Latency: press_ev is high in the cycle before edge N+2+DEBOUNCE_CYCLES; no backpressure.
module button_debouncer
  import mode_speed_selector_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press_ev
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  logic [1:0]    sync_q;
  logic          lvl;
  db_state_t     state_q, state_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;

  assign lvl = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {2{BTN_RST_LVL}};
      state_q <= DB_RST;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_n};
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      RELEASED: begin
        if (!lvl) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (lvl) begin
          state_nxt = RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_nxt = PRESSED;
        end else if (cnt_q != CNT_MAX) begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (lvl) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!lvl) begin
          state_nxt = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_nxt = RELEASED;
        end else if (cnt_q != CNT_MAX) begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    press_ev = 1'b0;
    if (state_q == PRESS_WAIT && !lvl && cnt_q == CNT_LAST) press_ev = 1'b1;
  end

endmodule

// File: rtl/mode_speed_selector.sv
// Cycles mode and speed selections on debounced button presses; upd pulses the cycle after a change.
// Latency: output moves at edge N+2+DEBOUNCE_CYCLES of a press from edge N, upd one edge later; no backpressure.
module mode_speed_selector
  import mode_speed_selector_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input logic                  clk,
  input logic                  rst_n,
  mode_speed_selector_if.master bus
);

  logic  mode_ev;
  logic  speed_ev;
  mode_t mode_q;
  spd_t  spd_q;
  logic  ev_q;
  logic  upd_q;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_n    (bus.btn_mode_n),
    .press_ev (mode_ev)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_speed (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_n    (bus.btn_speed_n),
    .press_ev (speed_ev)
  );

  // ev_q marks the edge the selectors moved, so upd lands one edge after the change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_RST;
      spd_q  <= SPD_RST;
      ev_q   <= 1'b0;
      upd_q  <= 1'b0;
    end else begin
      if (mode_ev)  mode_q <= next_mode(mode_q);
      if (speed_ev) spd_q  <= next_spd(spd_q);
      ev_q  <= mode_ev | speed_ev;
      upd_q <= ev_q;
    end
  end

  assign bus.mode     = mode_q;
  assign bus.clk_sw_1 = spd_q[1];
  assign bus.clk_sw_2 = spd_q[0];
  assign bus.upd      = upd_q;

endmodule

// File: doc/mode_speed_selector.md
MODE_SPEED_SELECTOR -- requirements
Module: mode_speed_selector

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, which is the number of consecutive stable clk cycles required to accept a button level change (20 ms at 50 MHz; legal range >= 1).
REQ-002 clk  input  1  single system clock (50 MHz board clock); all logic SHALL be synchronous to its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 btn_mode_n  input  1  raw mode push button, active-low, asynchronous and bouncy.
REQ-005 btn_speed_n  input  1  raw speed push button, active-low, asynchronous and bouncy.
REQ-006 mode  output  2  selected mode: 00 no mode, 01 repeat rule 1, 10 repeat rule 2, 11 automatic.
REQ-007 clk_sw_1  output  1  speed select MSB.
REQ-008 clk_sw_2  output  1  speed select LSB; {clk_sw_1,clk_sw_2}: 00 50 MHz, 01 1 Hz, 10 2 Hz, 11 4 Hz.
REQ-009 upd  output  1  one-cycle pulse on the cycle after mode or speed changes.

Function
REQ-010 Each button input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each button SHALL have an independent debounce FSM with states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 RELEASED -> PRESS_WAIT SHALL occur when the synchronized level is 0; the debounce counter is cleared on entry.
REQ-013 In PRESS_WAIT the counter SHALL increment each cycle the level stays 0; when the level returns to 1, the FSM SHALL go back to RELEASED.
REQ-014 When the counter reaches DEBOUNCE_CYCLES-1 with the level still 0, the FSM SHALL enter PRESSED and emit a one-cycle press event in that same cycle.
REQ-015 PRESSED -> RELEASE_WAIT -> RELEASED SHALL mirror REQ-012..014 for level 1 and SHALL emit no event.
REQ-016 A bounce shorter than DEBOUNCE_CYCLES SHALL produce no event.
REQ-017 Holding a button SHALL produce exactly one event (no auto-repeat).
REQ-018 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1); the counter SHALL saturate and never wrap.
REQ-019 A mode press event SHALL advance mode 00->01->10->11->00; 11 SHALL wrap to 00.
REQ-020 A speed press event SHALL advance {clk_sw_1,clk_sw_2} 01->10->11->00->01; 00 SHALL wrap to 01.
REQ-021 Mode and speed events in the same cycle SHALL both advance in that cycle, and upd SHALL pulse once.
REQ-022 Latency: a clean press held from edge N SHALL update its output at edge N+2+DEBOUNCE_CYCLES, and upd SHALL be high at edge N+3+DEBOUNCE_CYCLES only.
REQ-023 mode, clk_sw_1, clk_sw_2 and upd SHALL be registered outputs with no combinational path from the inputs.

Reset
REQ-024 While rst_n=0 the block SHALL hold mode=00, {clk_sw_1,clk_sw_2}=01, upd=0, both FSMs in RELEASED, and counters and synchronizers cleared to the released (1) level.
REQ-025 Reset asserted mid-debounce SHALL discard the pending event.
REQ-026 A button held low through reset deassertion SHALL be debounced from scratch and SHALL produce one event after REQ-022 latency.
REQ-027 Reset deassertion SHALL be treated as synchronized externally; no reset synchronizer SHALL be placed inside the block.

Structure
REQ-028 A shared package SHALL hold the mode encodings (MODE_NONE, MODE_RULE1, MODE_RULE2, MODE_AUTO), the speed encodings (SPD_50M, SPD_1HZ, SPD_2HZ, SPD_4HZ), the debounce FSM state enum, and the reset values.
REQ-029 Sub-module button_debouncer (synchronizer, FSM, counter, press-event output, parameter DEBOUNCE_CYCLES) SHALL be instantiated twice.
REQ-030 The top level SHALL contain only the two cyclic selector registers and the upd logic.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Reset release, no presses -> mode=00, clk_sw_1=0, clk_sw_2=1, upd=0 for 100 cycles.
REQ-032 btn_mode_n held low 10 cycles from edge N -> mode=01 at edge N+6, upd high at edge N+7 only; five such presses -> mode 01,10,11,00,01.
REQ-033 btn_speed_n low/high glitches of 1-3 cycles for 50 cycles, then low for 10 cycles -> exactly one change, speed 01->10; four more presses -> 11,00,01,10.
REQ-034 Both buttons pressed on the same edge -> mode and speed advance on the same edge, upd pulses once.
REQ-035 btn_mode_n low 2 cycles into debounce, then rst_n pulsed low while the button stays low -> outputs at reset values, then one event after the full latency from reset release.
REQ-036 Button held low 1000 cycles -> exactly one advance, and no further event on release.
